// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline skid stage: default payload width
// and the occupancy state encoding used at every pipeline boundary.
package pipe_skid_stage_pkg;

    // wd + wreg + wdata + hi/lo/hilo fields, as packed by the stages
    localparam int PSS_DATA_W = 70;

    // Encoding doubles as the occupancy count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pss_state_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages. in_ready and out_valid
// come straight from registered state, so out_ready never reaches in_ready
// combinationally, while one transfer per cycle is still sustained.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int DATA_W         = PSS_DATA_W,
    parameter bit ZERO_ON_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pss_state_e        state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              xfer_in;
    logic              xfer_out;

    // Handshake flags decoded from the registered state only
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_q;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    // Occupancy FSM with main/skid payload registers; flush beats any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
            if (ZERO_ON_BUBBLE) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        main_q  <= in_data;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_q <= in_data;
                    end else if (xfer_out) begin
                        state_q <= ST_EMPTY;
                        if (ZERO_ON_BUBBLE) main_q <= '0;
                    end else if (xfer_in) begin
                        skid_q  <= in_data;
                        state_q <= ST_TWO;
                    end
                end
                ST_TWO: begin
                    // Full: in_ready is low so in_data is ignored here
                    if (xfer_out) begin
                        main_q  <= skid_q;
                        state_q <= ST_ONE;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
